// File: rtl/pwm_duty_sequencer_if.sv
// Target-duty request channel between the control logic and pwm_duty_sequencer.
// A target transfers when tgt_valid and tgt_ready are both high on a rising edge.
interface pwm_duty_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             tgt_valid;
  logic [CNT_W-1:0] tgt_data;
  logic             tgt_ready;

  modport master (output tgt_valid, output tgt_data, input  tgt_ready);
  modport slave  (input  tgt_valid, input  tgt_data, output tgt_ready);
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Free-running PWM period counter plus duty sequencer; duty only moves on the counter wrap edge.
// PWM_RAMP_EN selects a slew-limited ramp (at most STEP per period); without it duty jumps to target on the first wrap.
module pwm_duty_sequencer #(
  parameter int CNT_W = 8,
  parameter int STEP  = 1
) (
  input  logic                       CLK,
  input  logic                       aRSTin,
  pwm_duty_sequencer_if.slave        tgt,
  output logic [CNT_W-1:0]           Din_out,
  output logic [CNT_W-1:0]           cnt,
  output logic                       period_start,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] duty_q;
  logic [CNT_W-1:0] duty_d;
  logic [CNT_W-1:0] tgt_q;
  logic             ps_q;
  logic             done_q;
  logic             busy_q;
  logic             ready_q;
  logic             wrap;

  assign wrap = (cnt_q == {CNT_W{1'b1}});

`ifdef PWM_RAMP_EN
  localparam logic [CNT_W:0] STEP_X = (CNT_W+1)'(STEP);

  // One extra bit keeps the distance and step arithmetic free of wrap-around.
  logic [CNT_W:0] tgt_x;
  logic [CNT_W:0] duty_x;
  logic [CNT_W:0] diff_x;

  always_comb begin
    tgt_x  = {1'b0, tgt_q};
    duty_x = {1'b0, duty_q};
    diff_x = '0;
    duty_d = duty_q;
    if (tgt_x > duty_x) begin
      diff_x = tgt_x - duty_x;
      duty_d = CNT_W'(duty_x + ((diff_x < STEP_X) ? diff_x : STEP_X));
    end else if (tgt_x < duty_x) begin
      diff_x = duty_x - tgt_x;
      duty_d = CNT_W'(duty_x - ((diff_x < STEP_X) ? diff_x : STEP_X));
    end
  end
`else
  assign duty_d = tgt_q;
`endif

  always_ff @(posedge CLK or posedge aRSTin) begin
    if (aRSTin) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      tgt_q   <= '0;
      ps_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CNT_W'(1);
      ps_q   <= wrap;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tgt.tgt_valid) begin
            tgt_q   <= tgt.tgt_data;
            state_q <= RUN;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        RUN: begin
          // Re-opening the handshake together with done allows back-to-back targets.
          if (wrap) begin
            duty_q <= duty_d;
            if (duty_d == tgt_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              done_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // A zero STEP would stall the ramp forever.
  assert property (@(posedge CLK) (STEP >= 1) && (STEP < (1 << CNT_W)));

  assign Din_out       = duty_q;
  assign cnt           = cnt_q;
  assign period_start  = ps_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign tgt.tgt_ready = ready_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench for pwm_duty_sequencer against a cycle-count based reference model.
// The model follows the ramp build when PWM_RAMP_EN is defined, otherwise the jump build.
module tb_pwm_duty_sequencer;
  localparam int CNT_W  = 8;
  localparam int STEP   = 5;
  localparam int PERIOD = 1 << CNT_W;
  localparam int BUDGET = 64 * PERIOD;
  localparam int VW     = 2 * CNT_W + 4;
`ifdef PWM_RAMP_EN
  localparam int EFF_STEP = STEP;
`else
  localparam int EFF_STEP = PERIOD;
`endif

  typedef struct {
    int              wraps;
    int              vec_bad;
    int              mid_chg;
    int              lat;
    int              excur;
    bit              got_done;
    int              bad_cyc;
    logic [VW-1:0]   bad_got;
    logic [VW-1:0]   bad_exp;
  } stat_t;

  logic             clk = 1'b0;
  logic             aRSTin;
  logic [CNT_W-1:0] Din_out;
  logic [CNT_W-1:0] cnt;
  logic             period_start;
  logic             busy;
  logic             done;

  pwm_duty_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pwm_duty_sequencer #(.CNT_W(CNT_W), .STEP(STEP)) dut (
    .CLK          (clk),
    .aRSTin       (aRSTin),
    .tgt          (bus),
    .Din_out      (Din_out),
    .cnt          (cnt),
    .period_start (period_start),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: cycles since reset release, applied duty, pending target.
  int m_cyc, m_duty, m_tgt;
  bit m_run, m_done, m_ps;

  function automatic int next_duty(int d, int t);
    if (t > d) return d + ((t - d < EFF_STEP) ? t - d : EFF_STEP);
    if (t < d) return d - ((d - t < EFF_STEP) ? d - t : EFF_STEP);
    return d;
  endfunction

  function automatic int exp_periods(int d, int t);
    int diff, p;
    diff = (t > d) ? t - d : d - t;
    p = (diff + EFF_STEP - 1) / EFF_STEP;
    return (p < 1) ? 1 : p;
  endfunction

  function automatic int exp_lat(int c);
    return (c == PERIOD - 1) ? PERIOD : PERIOD - 1 - c;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {CNT_W'(m_duty), CNT_W'(m_cyc % PERIOD), !m_run, m_run, m_done, m_ps};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {Din_out, cnt, bus.tgt_ready, busy, done, period_start};
  endfunction

  task automatic reset_model();
    m_cyc = 0; m_duty = 0; m_tgt = 0; m_run = 0; m_done = 0; m_ps = 0;
  endtask

  task automatic tick();
    bit acc, wrap;
    int dat;
    acc  = (bus.tgt_valid === 1'b1) && !m_run;
    dat  = int'(bus.tgt_data);
    wrap = (m_cyc % PERIOD) == PERIOD - 1;
    @(posedge clk);
    m_ps   = wrap;
    m_done = 0;
    if (m_run) begin
      if (wrap) begin
        m_duty = next_duty(m_duty, m_tgt);
        if (m_duty == m_tgt) begin m_run = 0; m_done = 1; end
      end
    end else if (acc) begin
      m_run = 1;
      m_tgt = dat;
    end
    m_cyc++;
    @(negedge clk);
  endtask

  task automatic tick_obs(inout stat_t s);
    tick();
    if (dut_vec() !== exp_vec()) begin
      s.vec_bad++;
      if (s.bad_cyc < 0) begin s.bad_cyc = m_cyc; s.bad_got = dut_vec(); s.bad_exp = exp_vec(); end
    end
  endtask

  // mode: -1 valid low while busy, -2 random valid/data noise, >=0 hold valid with that data.
  task automatic xfer(input int t, input int at_cnt, input int mode, output stat_t s);
    int lo, hi;
    logic [CNT_W-1:0] prev;
    s = '{default: 0};
    s.lat = -1;
    s.bad_cyc = -1;
    if (at_cnt >= 0) while ((m_cyc % PERIOD) != at_cnt) tick_obs(s);
    lo = (m_duty < t) ? m_duty : t;
    hi = (m_duty < t) ? t : m_duty;
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = CNT_W'(t);
    tick_obs(s);
    prev = Din_out;
    for (int i = 1; i <= BUDGET && !s.got_done; i++) begin
      if (mode >= 0) begin
        bus.tgt_valid = 1'b1; bus.tgt_data = CNT_W'(mode);
      end else if (mode == -2) begin
        bus.tgt_valid = 1'($urandom_range(0, 1)); bus.tgt_data = CNT_W'($urandom);
      end else begin
        bus.tgt_valid = 1'b0;
      end
      tick_obs(s);
      if (Din_out !== prev) begin
        if (cnt !== '0) s.mid_chg++;
        if (s.lat < 0) s.lat = i;
      end
      if (int'(Din_out) < lo || int'(Din_out) > hi) s.excur++;
      if (period_start === 1'b1) s.wraps++;
      if (done === 1'b1) s.got_done = 1;
      prev = Din_out;
    end
    if (mode < 0) bus.tgt_valid = 1'b0;
  endtask

  task automatic test_reset();
    stat_t s;
    int ps_n, ps_at[2];
    logic [VW-1:0] rst_exp;
    s = '{default: 0}; s.bad_cyc = -1;
    ps_n = 0; ps_at[0] = -1; ps_at[1] = -1;
    aRSTin = 1'b1;
    repeat (3) @(negedge clk);
    rst_exp = {CNT_W'(0), CNT_W'(0), 1'b1, 1'b0, 1'b0, 1'b0};
    checks++; if (dut_vec() !== rst_exp) begin errors++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), rst_exp); end
    aRSTin = 1'b0;
    reset_model();
    for (int i = 0; i < 600; i++) begin
      tick_obs(s);
      if (period_start === 1'b1) begin
        if (ps_n < 2) ps_at[ps_n] = m_cyc;
        ps_n++;
      end
    end
    checks++; if (s.vec_bad !== 0) begin errors++; $display("FAIL idle_vec bad=%0d cyc=%0d got=%h exp=%h", s.vec_bad, s.bad_cyc, s.bad_got, s.bad_exp); end
    checks++; if (ps_n !== 2) begin errors++; $display("FAIL idle_ps_count got=%0d exp=2", ps_n); end
    checks++; if (ps_at[0] !== 256) begin errors++; $display("FAIL idle_ps_first got=%0d exp=256", ps_at[0]); end
    checks++; if (ps_at[1] !== 512) begin errors++; $display("FAIL idle_ps_second got=%0d exp=512", ps_at[1]); end
  endtask

  task automatic test_ramp_up();
    stat_t s;
    int tg[2];
    int d0;
    tg[0] = 16; tg[1] = 32;
    for (int k = 0; k < 2; k++) begin
      d0 = m_duty;
      xfer(tg[k], (k == 0) ? 10 : -1, -1, s);
      checks++; if (!s.got_done) begin errors++; $display("FAIL up_done tgt=%0d got=0 exp=1", tg[k]); end
      checks++; if (s.vec_bad !== 0) begin errors++; $display("FAIL up_vec tgt=%0d bad=%0d cyc=%0d got=%h exp=%h", tg[k], s.vec_bad, s.bad_cyc, s.bad_got, s.bad_exp); end
      checks++; if (s.mid_chg !== 0) begin errors++; $display("FAIL up_mid_period_change got=%0d exp=0", s.mid_chg); end
      checks++; if (s.wraps !== exp_periods(d0, tg[k])) begin errors++; $display("FAIL up_wraps got=%0d exp=%0d", s.wraps, exp_periods(d0, tg[k])); end
      checks++; if (s.lat !== exp_lat((k == 0) ? 10 : 0)) begin errors++; $display("FAIL up_latency got=%0d exp=%0d", s.lat, exp_lat((k == 0) ? 10 : 0)); end
      checks++; if (int'(Din_out) !== tg[k]) begin errors++; $display("FAIL up_final got=%0d exp=%0d", Din_out, tg[k]); end
    end
  endtask

  task automatic test_ramp_down();
    stat_t s;
    xfer(128, int'($urandom_range(0, 255)), -1, s);
    checks++; if (!s.got_done || int'(Din_out) !== 128) begin errors++; $display("FAIL down_prep got=%0d exp=128", Din_out); end
    xfer(120, int'($urandom_range(0, 255)), -1, s);
    checks++; if (s.vec_bad !== 0) begin errors++; $display("FAIL down_vec bad=%0d cyc=%0d got=%h exp=%h", s.vec_bad, s.bad_cyc, s.bad_got, s.bad_exp); end
    checks++; if (s.excur !== 0) begin errors++; $display("FAIL down_undershoot got=%0d exp=0", s.excur); end
    checks++; if (s.wraps !== exp_periods(128, 120)) begin errors++; $display("FAIL down_wraps got=%0d exp=%0d", s.wraps, exp_periods(128, 120)); end
    checks++; if (int'(Din_out) !== 120) begin errors++; $display("FAIL down_final got=%0d exp=120", Din_out); end
  endtask

  task automatic test_back_to_back();
    stat_t s;
    xfer(32, int'($urandom_range(0, 255)), 200, s);
    checks++; if (!s.got_done) begin errors++; $display("FAIL b2b_done got=0 exp=1"); end
    checks++; if (s.vec_bad !== 0) begin errors++; $display("FAIL b2b_hold_vec bad=%0d cyc=%0d got=%h exp=%h", s.vec_bad, s.bad_cyc, s.bad_got, s.bad_exp); end
    checks++; if (bus.tgt_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done got=%b exp=1", bus.tgt_ready); end
    xfer(200, -1, -1, s);
    checks++; if (s.lat !== exp_lat(0)) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", s.lat, exp_lat(0)); end
    checks++; if (s.vec_bad !== 0) begin errors++; $display("FAIL b2b_vec bad=%0d cyc=%0d got=%h exp=%h", s.vec_bad, s.bad_cyc, s.bad_got, s.bad_exp); end
    checks++; if (s.wraps !== exp_periods(32, 200)) begin errors++; $display("FAIL b2b_wraps got=%0d exp=%0d", s.wraps, exp_periods(32, 200)); end
    checks++; if (int'(Din_out) !== 200) begin errors++; $display("FAIL b2b_final got=%0d exp=200", Din_out); end
  endtask

  task automatic test_boundary();
    stat_t s;
    int tg[4];
    xfer(205, PERIOD - 1, -1, s);
    checks++; if (s.lat !== PERIOD) begin errors++; $display("FAIL wrap_accept_latency got=%0d exp=%0d", s.lat, PERIOD); end
    checks++; if (s.vec_bad !== 0) begin errors++; $display("FAIL wrap_accept_vec bad=%0d cyc=%0d got=%h exp=%h", s.vec_bad, s.bad_cyc, s.bad_got, s.bad_exp); end
    tg[0] = 254; tg[1] = 255; tg[2] = 1; tg[3] = 0;
    for (int k = 0; k < 4; k++) begin
      xfer(tg[k], int'($urandom_range(0, 255)), -1, s);
      checks++; if (s.vec_bad !== 0 || s.excur !== 0) begin errors++; $display("FAIL edge_vec tgt=%0d bad=%0d excur=%0d got=%h exp=%h", tg[k], s.vec_bad, s.excur, s.bad_got, s.bad_exp); end
      checks++; if (int'(Din_out) !== tg[k]) begin errors++; $display("FAIL edge_final got=%0d exp=%0d", Din_out, tg[k]); end
    end
  endtask

  task automatic test_random();
    stat_t s;
    int d0, t, c, el;
    for (int k = 0; k < 4; k++) begin
      d0 = m_duty;
      t  = d0 + int'($urandom_range(0, 60)) - 30;
      if (t < 0) t = 0;
      if (t > PERIOD - 1) t = PERIOD - 1;
      c  = int'($urandom_range(0, PERIOD - 1));
      el = (t == d0) ? -1 : exp_lat(c);
      xfer(t, c, -2, s);
      checks++; if (!s.got_done) begin errors++; $display("FAIL rnd_done tgt=%0d got=0 exp=1", t); end
      checks++; if (s.vec_bad !== 0) begin errors++; $display("FAIL rnd_vec tgt=%0d bad=%0d cyc=%0d got=%h exp=%h", t, s.vec_bad, s.bad_cyc, s.bad_got, s.bad_exp); end
      checks++; if (s.wraps !== exp_periods(d0, t)) begin errors++; $display("FAIL rnd_wraps got=%0d exp=%0d", s.wraps, exp_periods(d0, t)); end
      checks++; if (s.lat !== el) begin errors++; $display("FAIL rnd_latency got=%0d exp=%0d", s.lat, el); end
    end
  endtask

  task automatic test_reset_midramp();
    stat_t s;
    int done_n, nz_n;
    xfer(20, int'($urandom_range(0, 255)), -1, s);
    checks++; if (s.vec_bad !== 0 || int'(Din_out) !== 20) begin errors++; $display("FAIL mid_prep got=%0d exp=20", Din_out); end
    s = '{default: 0}; s.bad_cyc = -1;
    while ((m_cyc % PERIOD) != 10) tick_obs(s);
    bus.tgt_valid = 1'b1; bus.tgt_data = CNT_W'(128);
    tick_obs(s);
    bus.tgt_valid = 1'b0;
    repeat (100) tick_obs(s);
    checks++; if (busy !== 1'b1 || int'(Din_out) !== 20) begin errors++; $display("FAIL mid_running got busy=%b din=%0d exp busy=1 din=20", busy, Din_out); end
    aRSTin = 1'b1;
    #1;
    checks++; if (Din_out !== '0 || bus.tgt_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_async_reset got din=%0d rdy=%b busy=%b exp 0/1/0", Din_out, bus.tgt_ready, busy); end
    repeat (2) @(negedge clk);
    checks++; if (cnt !== '0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset_hold got cnt=%0d done=%b exp 0/0", cnt, done); end
    aRSTin = 1'b0;
    reset_model();
    s = '{default: 0}; s.bad_cyc = -1;
    done_n = 0; nz_n = 0;
    for (int i = 0; i < 600; i++) begin
      tick_obs(s);
      if (done === 1'b1) done_n++;
      if (Din_out !== '0) nz_n++;
    end
    checks++; if (s.vec_bad !== 0) begin errors++; $display("FAIL mid_after_vec bad=%0d cyc=%0d got=%h exp=%h", s.vec_bad, s.bad_cyc, s.bad_got, s.bad_exp); end
    checks++; if (done_n !== 0) begin errors++; $display("FAIL mid_after_done got=%0d exp=0", done_n); end
    checks++; if (nz_n !== 0) begin errors++; $display("FAIL mid_after_duty got=%0d exp=0", nz_n); end
  endtask

  initial begin
    aRSTin        = 1'b1;
    bus.tgt_valid = 1'b0;
    bus.tgt_data  = '0;
    reset_model();
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_back_to_back();
    test_boundary();
    test_random();
    test_reset_midramp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
